serial_word_arbiter: RTL and testbench
======================================

// Module: serial_word_arbiter
// PURPOSE
//   Shares one serial_to_parallel deserializer between n_req serial requesters.
//   Grants the deserializer to one requester for exactly one width-bit word,
//   round-robin, and muxes that requester's bit stream into the deserializer.
//   Returns each assembled word tagged with the id of the requester that sent it.
// PARAMETERS
//   n_req  4  number of serial requesters, >= 2
//   width  8  bits per word; must equal the deserializer's width
// PORTS
//   clk               in   1                 clock
//   rst               in   1                 sync reset, active-high
//   req               in   n_req             requester i wants to send one word
//   in_valid          in   n_req             bit strobe per requester
//   in_data           in   n_req             serial bit per requester
//   grant             out  n_req             one-hot; owner may drive bits
//   des_serial_valid  out  1                 to deserializer serial_valid
//   des_serial_data   out  1                 to deserializer serial_data
//   des_par_valid     in   1                 from deserializer parallel_valid
//   des_par_data      in   width             from deserializer parallel_data
//   out_valid         out  1                 tagged word available, 1-cycle pulse
//   out_data          out  width             assembled word
//   out_id            out  $clog2(n_req)     requester index of out_data
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - Reset values: grant=0, out_valid=0, out_data=0, out_id=0, bit count=0,
//     rr pointer=0, state IDLE.
//   - States:
//     - IDLE: if req!=0, pick the first set req bit at or above the pointer,
//       wrapping. Register owner and set grant next cycle. Go to BUSY.
//     - BUSY: des_serial_valid = in_valid[owner]; des_serial_data = in_data[owner].
//       Count only cycles with in_valid[owner]=1. On the accepted bit with
//       count==width-1: drop grant next cycle, reset count, go to WAIT.
//       If des_par_valid is also high that cycle, go directly to IDLE.
//     - WAIT: grant=0, des_serial_valid=0. On des_par_valid go to IDLE.
//       Owner is held until the word returns.
//   - When des_par_valid is accepted in BUSY(last bit) or WAIT: out_valid=1,
//     out_data=des_par_data, out_id=owner, all on the next cycle (1-cycle latency).
//     The pointer becomes owner+1 mod n_req.
//   - des_par_valid in IDLE, or in BUSY before the last bit, is ignored:
//     no out_valid.
//   - While not BUSY, des_serial_valid=0 and des_serial_data=0.
//   - in_valid from non-granted requesters is ignored.
//   - req dropped mid-word is ignored: the grant holds until width bits are accepted.
//   - Fairness: a requester holding req is granted within n_req words.
//   - Gaps in in_valid never advance the count. There is no timeout.
//   - Reset mid-word: the partial word is discarded and no out_valid is produced.
//     The deserializer shares rst.
//   - No re-grant in the same cycle a word completes. The minimum IDLE gap is 1 cycle.
// TESTING
//   1. req=0001; send 0xA5 LSB-first, contiguous -> grant=0001 one cycle after
//      req; 8 des_serial_valid pulses; out_valid 1 cycle after des_par_valid,
//      out_data=0xA5, out_id=0.
//   2. req=1111 held; each owner sends its index -> grants 0,1,2,3,0 in order;
//      out_id sequence 0,1,2,3,0.
//   3. Owner 1 sends 0x3C with 1-3 idle cycles between bits -> count advances
//      only on in_valid; grant held throughout; out_data=0x3C, out_id=1.
//   4. in_valid/in_data toggled on requester 2 while 0 is granted ->
//      des_serial_valid follows requester 0 only; out_id=0.
//   5. rst high after 3 bits accepted -> next cycle grant=0, out_valid=0;
//      then a full word 0xFF -> out_data=0xFF, no stale bits.
//   6. Last grant=2, then req=0101 -> next grant 0 (wraps past 3), then 2.

Source files
------------

// File: rtl/serial_word_arbiter.sv
// -----------------------------------------------------------------------------
// serial_word_arbiter
//   Shares one serial-to-parallel deserializer between n_req serial requesters.
//   Each grant covers exactly one width-bit word. Grants rotate round-robin.
//   The owner's bit stream is muxed onto the deserializer input. Each assembled
//   word comes back tagged with the id of the requester that sent it.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[n]            requester i wants to send one word
//   in_valid[n]       per-requester bit strobe
//   in_data[n]        per-requester serial bit
//   grant[n]          one-hot, registered; the owner may drive bits
//   des_serial_valid  bit strobe to the deserializer (owner's in_valid while BUSY)
//   des_serial_data   bit to the deserializer (owner's in_data while BUSY)
//   des_par_valid     word-ready strobe from the deserializer
//   des_par_data      assembled word from the deserializer
//   out_valid         one-cycle pulse, tagged word available
//   out_data          assembled word
//   out_id            requester index of out_data
//   dbg_state         current FSM state (0 IDLE, 1 BUSY, 2 WAIT)
//
// Handshake: a bit transfers on every cycle where des_serial_valid is high.
// There is no back-pressure. A returned word is taken on any cycle where
// des_par_valid is high while a word is outstanding: the last-bit cycle of
// BUSY, or any cycle of WAIT. des_par_valid seen at any other time is dropped.
// -----------------------------------------------------------------------------
module serial_word_arbiter #(
  parameter int n_req = 4,
  parameter int width = 8,
  localparam int ID_W  = (n_req > 1) ? $clog2(n_req) : 1,
  localparam int CNT_W = (width > 1) ? $clog2(width) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [n_req-1:0]   req,
  input  logic [n_req-1:0]   in_valid,
  input  logic [n_req-1:0]   in_data,
  output logic [n_req-1:0]   grant,
  output logic               des_serial_valid,
  output logic               des_serial_data,
  input  logic               des_par_valid,
  input  logic [width-1:0]   des_par_data,
  output logic               out_valid,
  output logic [width-1:0]   out_data,
  output logic [ID_W-1:0]    out_id,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [n_req-1:0]   grant_q;
  logic               out_valid_q;
  logic [width-1:0]   out_data_q;
  logic [ID_W-1:0]    out_id_q;

  logic               pick_found;
  logic [ID_W-1:0]    pick_d;
  logic [n_req-1:0]   pick_onehot_d;
  logic [ID_W-1:0]    ptr_d;
  logic               bit_vld;
  logic               bit_dat;
  logic               last_bit;
  logic [ID_W:0]      scan_sum;

  // Round-robin scan: first set req bit at or above the pointer, wrapping.
  // The sum is one bit wider so the wrap compare cannot overflow.
  always_comb begin
    pick_found    = 1'b0;
    pick_d        = '0;
    pick_onehot_d = '0;
    scan_sum      = '0;
    for (int i = 0; i < n_req; i++) begin
      scan_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(n_req)) begin
        scan_sum = scan_sum - (ID_W+1)'(n_req);
      end
      if (!pick_found && req[scan_sum[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_d     = scan_sum[ID_W-1:0];
      end
    end
    pick_onehot_d[pick_d] = 1'b1;
  end

  // The pointer moves past the owner only once its word has been returned.
  always_comb begin
    if (owner_q == ID_W'(n_req - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = owner_q + 1'b1;
    end
  end

  // Only the owner reaches the deserializer, and only while BUSY.
  always_comb begin
    bit_vld  = (state_q == S_BUSY) && in_valid[owner_q];
    bit_dat  = (state_q == S_BUSY) && in_data[owner_q];
    last_bit = bit_vld && (cnt_q == CNT_W'(width - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            owner_q <= pick_d;
            grant_q <= pick_onehot_d;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (last_bit) begin
            grant_q <= '0;
            cnt_q   <= '0;
            // A deserializer with no output register can return the word
            // in the same cycle as the last bit; skip WAIT in that case.
            if (des_par_valid) begin
              out_valid_q <= 1'b1;
              out_data_q  <= des_par_data;
              out_id_q    <= owner_q;
              ptr_q       <= ptr_d;
              state_q     <= S_IDLE;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (bit_vld) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (des_par_valid) begin
            out_valid_q <= 1'b1;
            out_data_q  <= des_par_data;
            out_id_q    <= owner_q;
            ptr_q       <= ptr_d;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant            = grant_q;
  assign des_serial_valid = bit_vld;
  assign des_serial_data  = bit_dat;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_id           = out_id_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_serial_word_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_word_arbiter
//   Directed bench for serial_word_arbiter with n_req=4, width=8. A small
//   LSB-first deserializer model answers des_serial_* one cycle after the
//   eighth bit. A manual mode lets a test drive des_par_* directly. Inputs
//   are driven 1 time unit after posedge. A monitor samples at negedge.
// -----------------------------------------------------------------------------
module tb_serial_word_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] in_valid;
  logic [3:0] in_data;
  logic [3:0] grant;
  logic       dsv;
  logic       dsd;
  logic       dpv;
  logic [7:0] dpd;
  logic       ov;
  logic [7:0] od;
  logic [1:0] oid;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_arbiter #(.n_req(4), .width(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .grant            (grant),
    .des_serial_valid (dsv),
    .des_serial_data  (dsd),
    .des_par_valid    (dpv),
    .des_par_data     (dpd),
    .out_valid        (ov),
    .out_data         (od),
    .out_id           (oid),
    .dbg_state        (dbg_state)
  );

  // Deserializer model: LSB-first, word valid the cycle after the 8th bit.
  logic       manual = 1'b0;
  logic       manual_pv = 1'b0;
  logic [7:0] manual_pd = 8'h00;
  logic [7:0] m_sh;
  logic [2:0] m_cnt;
  logic       model_pv;
  logic [7:0] model_pd;

  always @(posedge clk) begin
    if (rst) begin
      m_sh <= 8'h00; m_cnt <= 3'd0; model_pv <= 1'b0; model_pd <= 8'h00;
    end else begin
      model_pv <= 1'b0;
      if (dsv) begin
        m_sh <= {dsd, m_sh[7:1]};
        if (m_cnt == 3'd7) begin
          model_pd <= {dsd, m_sh[7:1]};
          model_pv <= 1'b1;
          m_cnt    <= 3'd0;
        end else begin
          m_cnt <= m_cnt + 3'd1;
        end
      end
    end
  end

  assign dpv = manual ? manual_pv : model_pv;
  assign dpd = manual ? manual_pd : model_pd;

  // Monitor: serial pulse count, returned words and their latency.
  int         cyc = 0;
  int         dpv_cyc = 0;
  int         ser_cnt = 0;
  logic [9:0] got_q[$];
  int         lat_q[$];
  int         got_rd = 0;
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dsv) ser_cnt = ser_cnt + 1;
    if (dpv) dpv_cyc = cyc;
    if (ov) begin
      got_q.push_back({oid, od});
      lat_q.push_back(cyc - dpv_cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 4'b0; in_valid = 4'b0; in_data = 4'b0;
    manual = 1'b0; manual_pv = 1'b0; manual_pd = 8'h00;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_any_grant(output bit ok, output logic [1:0] gid);
    ok = 1'b0; gid = 2'd0;
    for (int k = 0; k < 20; k++) begin
      if (grant != 4'b0) begin
        ok = 1'b1;
        for (int j = 0; j < 4; j++) if (grant[2'(j)]) gid = 2'(j);
        break;
      end
      tick();
    end
  endtask

  task automatic noise(input bit en, input logic [1:0] nid);
    if (en) begin
      in_valid[nid] = ~in_valid[nid];
      in_data[nid]  = ~in_data[nid];
    end
  endtask

  // Sends nbits of w LSB-first from requester id. gapped inserts 1..3 idle
  // cycles before each bit. held drops to 0 if grant[id] is ever low at a bit.
  task automatic send_bits(input logic [1:0] id, input logic [7:0] w, input int nbits,
                           input bit gapped, input bit nz, input logic [1:0] nid,
                           output bit held);
    held = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      if (gapped) begin
        in_valid[id] = 1'b0;
        for (int g = 0; g < (b % 3) + 1; g++) begin
          noise(nz, nid);
          tick();
        end
      end
      if (!grant[id]) held = 1'b0;
      in_valid[id] = 1'b1;
      in_data[id]  = w[3'(b)];
      noise(nz, nid);
      tick();
    end
    in_valid[id] = 1'b0;
    in_data[id]  = 1'b0;
    if (nz) begin
      in_valid[nid] = 1'b0;
      in_data[nid]  = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok, output logic [9:0] entry, output int lat);
    ok = 1'b0; entry = 10'h0; lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (got_q.size() > got_rd) begin
        ok    = 1'b1;
        entry = got_q[got_rd];
        lat   = lat_q[got_rd];
        got_rd++;
        break;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; req = 4'b0; in_valid = 4'b1111; in_data = 4'b1111;
    manual = 1'b0; manual_pv = 1'b0; manual_pd = 8'h00;
    tick(2);
    checks++;
    if (grant !== 4'b0 || ov !== 1'b0 || od !== 8'h00 || oid !== 2'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values grant=%b ov=%b od=%h oid=%0d st=%0d required 0000 0 00 0 0",
               grant, ov, od, oid, dbg_state);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dsv !== 1'b0 || dsd !== 1'b0) begin
      errors++;
      $display("FAIL idle_serial_gate dsv=%b dsd=%b required 0 0", dsv, dsd);
    end
    in_valid = 4'b0; in_data = 4'b0;
  endtask

  task automatic test_single_word;
    bit ok; bit held; logic [9:0] e; int lat; int ser0; logic [9:0] exp;
    do_reset();
    req = 4'b0001;
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL t1_grant_before got=%b required 0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL t1_grant_latency got=%b required 0001", grant);
    end
    req = 4'b0000;
    ser0 = ser_cnt;
    exp_q.push_back({2'd0, 8'hA5});
    send_bits(2'd0, 8'hA5, 8, 1'b0, 1'b0, 2'd0, held);
    wait_out(ok, e, lat);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || e !== exp) begin
      errors++; $display("FAIL t1_word ok=%0b got=%h required %h", ok, e, exp);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL t1_out_latency got=%0d required 1", lat);
    end
    checks++;
    if (ser_cnt - ser0 !== 8) begin
      errors++; $display("FAIL t1_serial_pulses got=%0d required 8", ser_cnt - ser0);
    end
    tick(3);
    checks++;
    if (got_q.size() !== got_rd) begin
      errors++; $display("FAIL t1_single_pulse extra=%0d required 0", got_q.size() - got_rd);
    end
  endtask

  task automatic test_round_robin;
    bit ok; bit held; logic [9:0] e; int lat; logic [1:0] gid; logic [9:0] exp;
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1) << (k % 4);
      wait_any_grant(ok, gid);
      checks++;
      if (!ok || grant !== exp_g) begin
        errors++; $display("FAIL t2_grant_%0d ok=%0b got=%b required %b", k, ok, grant, exp_g);
      end
      if (k == 4) req = 4'b0000;
      exp_q.push_back({2'(k % 4), 8'(k % 4)});
      send_bits(gid, 8'(gid), 8, 1'b0, 1'b0, 2'd0, held);
      wait_out(ok, e, lat);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || e !== exp) begin
        errors++; $display("FAIL t2_word_%0d ok=%0b got=%h required %h", k, ok, e, exp);
      end
    end
  endtask

  task automatic test_gaps;
    bit ok; bit held; logic [9:0] e; int lat; logic [1:0] gid; int ser0; logic [9:0] exp;
    do_reset();
    req = 4'b0010;
    wait_any_grant(ok, gid);
    req = 4'b0000;
    checks++;
    if (!ok || grant !== 4'b0010) begin
      errors++; $display("FAIL t3_grant ok=%0b got=%b required 0010", ok, grant);
    end
    ser0 = ser_cnt;
    exp_q.push_back({2'd1, 8'h3C});
    send_bits(2'd1, 8'h3C, 8, 1'b1, 1'b0, 2'd0, held);
    checks++;
    if (held !== 1'b1) begin
      errors++; $display("FAIL t3_grant_held got=%0b required 1", held);
    end
    wait_out(ok, e, lat);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || e !== exp || ser_cnt - ser0 !== 8) begin
      errors++; $display("FAIL t3_word ok=%0b got=%h pulses=%0d required %h pulses 8",
                         ok, e, ser_cnt - ser0, exp);
    end
  endtask

  task automatic test_isolation;
    bit ok; bit held; logic [9:0] e; int lat; logic [1:0] gid; int ser0; logic [9:0] exp;
    do_reset();
    req = 4'b0001;
    wait_any_grant(ok, gid);
    req = 4'b0000;
    ser0 = ser_cnt;
    exp_q.push_back({2'd0, 8'h96});
    send_bits(2'd0, 8'h96, 8, 1'b1, 1'b1, 2'd2, held);
    wait_out(ok, e, lat);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || e !== exp) begin
      errors++; $display("FAIL t4_word ok=%0b got=%h required %h", ok, e, exp);
    end
    checks++;
    if (ser_cnt - ser0 !== 8) begin
      errors++; $display("FAIL t4_serial_pulses got=%0d required 8", ser_cnt - ser0);
    end
  endtask

  task automatic test_mid_reset;
    bit ok; bit held; logic [9:0] e; int lat; logic [1:0] gid; int got0; logic [9:0] exp;
    do_reset();
    req = 4'b0001;
    wait_any_grant(ok, gid);
    req = 4'b0000;
    got0 = got_q.size();
    send_bits(2'd0, 8'h00, 3, 1'b0, 1'b0, 2'd0, held);
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0000 || ov !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL t5_after_reset grant=%b ov=%b st=%0d required 0000 0 0",
                         grant, ov, dbg_state);
    end
    rst = 1'b0;
    tick(4);
    checks++;
    if (got_q.size() !== got0) begin
      errors++; $display("FAIL t5_no_partial_word got=%0d words required 0", got_q.size() - got0);
    end
    req = 4'b0001;
    wait_any_grant(ok, gid);
    req = 4'b0000;
    exp_q.push_back({2'd0, 8'hFF});
    send_bits(2'd0, 8'hFF, 8, 1'b0, 1'b0, 2'd0, held);
    wait_out(ok, e, lat);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || e !== exp) begin
      errors++; $display("FAIL t5_word ok=%0b got=%h required %h", ok, e, exp);
    end
  endtask

  task automatic test_wrap;
    bit ok; bit held; logic [9:0] e; int lat; logic [1:0] gid;
    logic [1:0] exp_ids[3];
    logic [7:0] words[3];
    exp_ids = '{2'd2, 2'd0, 2'd2};
    words   = '{8'h11, 8'h22, 8'h33};
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_any_grant(ok, gid);
      checks++;
      if (!ok || gid !== exp_ids[k]) begin
        errors++; $display("FAIL t6_grant_%0d ok=%0b got=%0d required %0d", k, ok, gid, exp_ids[k]);
      end
      if (k == 0) req = 4'b0101;
      if (k == 2) req = 4'b0000;
      send_bits(gid, words[k], 8, 1'b0, 1'b0, 2'd0, held);
      wait_out(ok, e, lat);
      checks++;
      if (!ok || e !== {exp_ids[k], words[k]}) begin
        errors++; $display("FAIL t6_word_%0d ok=%0b got=%h required %h", k, ok, e, {exp_ids[k], words[k]});
      end
    end
  endtask

  // Word returned in the same cycle as its last bit; stray des_par_valid in
  // IDLE and early in BUSY must be dropped.
  task automatic test_direct_return;
    bit ok; logic [1:0] gid; int got0;
    logic [7:0] w;
    w = 8'hC3;
    do_reset();
    manual = 1'b1;
    got0 = got_q.size();
    manual_pv = 1'b1; manual_pd = 8'hEE;
    tick();
    manual_pv = 1'b0;
    tick(2);
    checks++;
    if (got_q.size() !== got0) begin
      errors++; $display("FAIL t7_idle_par_ignored got=%0d words required 0", got_q.size() - got0);
    end
    req = 4'b1000;
    wait_any_grant(ok, gid);
    req = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      in_valid[3] = 1'b1;
      in_data[3]  = w[3'(b)];
      manual_pv   = (b == 2) || (b == 7);
      manual_pd   = (b == 7) ? 8'h5A : 8'hEE;
      tick();
    end
    in_valid = 4'b0; in_data = 4'b0; manual_pv = 1'b0;
    checks++;
    if (ov !== 1'b1 || od !== 8'h5A || oid !== 2'd3 || grant !== 4'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL t7_direct ov=%b od=%h oid=%0d grant=%b st=%0d required 1 5a 3 0000 0",
                         ov, od, oid, grant, dbg_state);
    end
    tick(2);
    checks++;
    if (got_q.size() - got0 !== 1) begin
      errors++; $display("FAIL t7_word_count got=%0d required 1", got_q.size() - got0);
    end
    got_rd = got_q.size();
    manual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_gaps();
    test_isolation();
    test_mid_reset();
    test_wrap();
    test_direct_return();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
